pc_btb: RTL and testbench

PC_BTB -- requirements
Module: pc_btb

---
 rtl/pc_btb_if.sv | 25 ++
 rtl/pc_btb.sv | 90 +++++++++
 tb/tb_pc_btb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pc_btb_if.sv
// Fetch-side bundle for pc_btb: PC control, resolved-branch update, and
// the registered fetch PC with its BTB prediction.
interface pc_btb_if;
    logic        pcen;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] imemaddr;
    logic [31:0] npc;
    logic        pred_taken;
    logic [31:0] pred_target;

    modport master (
        output pcen, redirect, redirect_pc, upd_en, upd_pc, upd_taken, upd_target,
        input  imemaddr, npc, pred_taken, pred_target
    );

    modport slave (
        input  pcen, redirect, redirect_pc, upd_en, upd_pc, upd_taken, upd_target,
        output imemaddr, npc, pred_taken, pred_target
    );
endinterface

// File: rtl/pc_btb.sv
// Program counter with a direct-mapped branch target buffer.
// Each entry holds valid, tag, target and a 2-bit saturating direction counter.
module pc_btb #(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input logic     CLK,
    input logic     nRST,
    pc_btb_if.slave bus
);
    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = 30 - IDX;

    logic              valid_q [ENTRIES];
    logic [TAGW-1:0]   tag_q   [ENTRIES];
    logic [31:0]       tgt_q   [ENTRIES];
    logic [1:0]        ctr_q   [ENTRIES];

    logic [31:0]       pc_q;
    logic [31:0]       pc_d;
    logic [IDX-1:0]    lidx;
    logic [IDX-1:0]    uidx;
    logic [TAGW-1:0]   ltag;
    logic [TAGW-1:0]   utag;
    logic              lhit;
    logic              uhit;
    logic              ptaken;

    // Lookup at the current fetch PC and update-side index/tag decode
    always_comb begin
        lidx   = pc_q[IDX+1:2];
        ltag   = pc_q[31:IDX+2];
        uidx   = bus.upd_pc[IDX+1:2];
        utag   = bus.upd_pc[31:IDX+2];
        lhit   = valid_q[lidx] && (tag_q[lidx] == ltag);
        uhit   = valid_q[uidx] && (tag_q[uidx] == utag);
        ptaken = lhit && ctr_q[lidx][1];
    end

    assign bus.imemaddr    = pc_q;
    assign bus.npc         = pc_q + 32'd4;
    assign bus.pred_taken  = ptaken;
    assign bus.pred_target = ptaken ? tgt_q[lidx] : '0;

    // Next-PC select: redirect beats prediction beats sequential, else hold
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect)
            pc_d = bus.redirect_pc;
        else if (bus.pcen && ptaken)
            pc_d = tgt_q[lidx];
        else if (bus.pcen)
            pc_d = pc_q + 32'd4;
    end

    // Fetch PC register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pc_q <= PC_RESET;
        else
            pc_q <= pc_d;
    end

    // BTB update: train on a tag hit, allocate only on a taken miss
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (bus.upd_en) begin
            if (uhit) begin
                if (bus.upd_taken) begin
                    if (ctr_q[uidx] != 2'b11)
                        ctr_q[uidx] <= ctr_q[uidx] + 2'd1;
                    tgt_q[uidx] <= bus.upd_target;
                end else if (ctr_q[uidx] != 2'b00) begin
                    ctr_q[uidx] <= ctr_q[uidx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                valid_q[uidx] <= 1'b1;
                tag_q[uidx]   <= utag;
                tgt_q[uidx]   <= bus.upd_target;
                ctr_q[uidx]   <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_pc_btb.sv
// Directed self-checking bench for pc_btb (ENTRIES=16, PC_RESET=0).
module tb_pc_btb;
    logic CLK;
    logic nRST;
    int   total;
    int   bad;

    pc_btb_if bus ();

    pc_btb #(.ENTRIES(16), .PC_RESET(32'h0000_0000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge; outputs sampled 1ns after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.pcen        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.upd_en      = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = '0;
    endtask

    task automatic redir(input logic [31:0] pc);
        bus.redirect = 1'b1; bus.redirect_pc = pc;
        tick();
        bus.redirect = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.upd_en = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tgt;
        tick();
        bus.upd_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        nRST = 1'b0;
        #12;
        total++; if (bus.imemaddr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.imemaddr, 32'h0); end
        total++; if (bus.npc !== 32'h4) begin bad++; $display("FAIL reset_npc got=%h exp=%h", bus.npc, 32'h4); end
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pt got=%b exp=0", bus.pred_taken); end
        total++; if (bus.pred_target !== 32'h0) begin bad++; $display("FAIL reset_ptgt got=%h exp=0", bus.pred_target); end
        #2 nRST = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        bus.pcen = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = i * 4;
            total++; if (bus.imemaddr !== exp) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.imemaddr, exp); end
            total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL seq_pt%0d got=%b exp=0", i, bus.pred_taken); end
        end
        bus.pcen = 1'b0;
    endtask

    task automatic test_alloc();
        upd(32'h40, 1'b1, 32'h100);
        total++; if (bus.imemaddr !== 32'hC) begin bad++; $display("FAIL alloc_hold got=%h exp=%h", bus.imemaddr, 32'hC); end
        redir(32'h40);
        total++; if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_pt got=%b exp=1", bus.pred_taken); end
        total++; if (bus.pred_target !== 32'h100) begin bad++; $display("FAIL alloc_ptgt got=%h exp=%h", bus.pred_target, 32'h100); end
        bus.pcen = 1'b1;
        tick();
        bus.pcen = 1'b0;
        total++; if (bus.imemaddr !== 32'h100) begin bad++; $display("FAIL alloc_follow got=%h exp=%h", bus.imemaddr, 32'h100); end
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL alloc_other got=%b exp=0", bus.pred_taken); end
    endtask

    task automatic test_counter();
        // 10 -> 01 (low bits of upd_pc must be ignored)
        upd(32'h43, 1'b0, 32'h0);
        redir(32'h40);
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL nt1_pt got=%b exp=0", bus.pred_taken); end
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0);
        bus.pcen = 1'b1;
        tick();
        bus.pcen = 1'b0;
        total++; if (bus.imemaddr !== 32'h44) begin bad++; $display("FAIL nt_fall got=%h exp=%h", bus.imemaddr, 32'h44); end
        // Saturated at 00: one taken gives 01 (still not taken)
        upd(32'h40, 1'b1, 32'h100);
        redir(32'h40);
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL sat00_pt got=%b exp=0", bus.pred_taken); end
        // 01 -> 10 with new target
        upd(32'h40, 1'b1, 32'h180);
        total++; if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL t2_pt got=%b exp=1", bus.pred_taken); end
        total++; if (bus.pred_target !== 32'h180) begin bad++; $display("FAIL t2_tgt got=%h exp=%h", bus.pred_target, 32'h180); end
        // 10 -> 11 -> 11, then one not-taken leaves 10 (taken)
        upd(32'h40, 1'b1, 32'h180);
        upd(32'h40, 1'b1, 32'h180);
        upd(32'h40, 1'b0, 32'h0);
        total++; if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL sat11_pt got=%b exp=1", bus.pred_taken); end
    endtask

    task automatic test_alias();
        upd(32'h440, 1'b1, 32'h500);
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL alias_old_pt got=%b exp=0", bus.pred_taken); end
        bus.pcen = 1'b1;
        tick();
        bus.pcen = 1'b0;
        total++; if (bus.imemaddr !== 32'h44) begin bad++; $display("FAIL alias_fall got=%h exp=%h", bus.imemaddr, 32'h44); end
        redir(32'h440);
        total++; if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL alias_new_pt got=%b exp=1", bus.pred_taken); end
        total++; if (bus.pred_target !== 32'h500) begin bad++; $display("FAIL alias_new_tgt got=%h exp=%h", bus.pred_target, 32'h500); end
    endtask

    task automatic test_conflict();
        // At 0x440 predicting taken; redirect with pcen=0 and a concurrent update
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        bus.upd_en = 1'b1; bus.upd_pc = 32'h204; bus.upd_taken = 1'b1; bus.upd_target = 32'h300;
        tick();
        idle();
        total++; if (bus.imemaddr !== 32'h200) begin bad++; $display("FAIL redir_pc got=%h exp=%h", bus.imemaddr, 32'h200); end
        redir(32'h204);
        total++; if (bus.pred_target !== 32'h300) begin bad++; $display("FAIL redir_upd_tgt got=%h exp=%h", bus.pred_target, 32'h300); end
        // Same-index lookup and not-taken update: lookup uses old counter
        bus.pcen = 1'b1;
        bus.upd_en = 1'b1; bus.upd_pc = 32'h204; bus.upd_taken = 1'b0;
        tick();
        idle();
        total++; if (bus.imemaddr !== 32'h300) begin bad++; $display("FAIL same_idx_pc got=%h exp=%h", bus.imemaddr, 32'h300); end
        redir(32'h204);
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL same_idx_after got=%b exp=0", bus.pred_taken); end
    endtask

    task automatic test_wrap();
        redir(32'hFFFF_FFFC);
        total++; if (bus.npc !== 32'h0) begin bad++; $display("FAIL wrap_npc got=%h exp=0", bus.npc); end
        bus.pcen = 1'b1;
        tick();
        bus.pcen = 1'b0;
        total++; if (bus.imemaddr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", bus.imemaddr); end
    endtask

    task automatic test_async_reset();
        upd(32'h300, 1'b1, 32'h340);
        redir(32'h300);
        total++; if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL ar_pre_pt got=%b exp=1", bus.pred_taken); end
        #2 nRST = 1'b0;
        #1;
        total++; if (bus.imemaddr !== 32'h0) begin bad++; $display("FAIL ar_pc got=%h exp=0", bus.imemaddr); end
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL ar_pt got=%b exp=0", bus.pred_taken); end
        total++; if (bus.npc !== 32'h4) begin bad++; $display("FAIL ar_npc got=%h exp=%h", bus.npc, 32'h4); end
        // Strobes during reset must be ignored
        bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
        bus.upd_en = 1'b1; bus.upd_pc = 32'h0; bus.upd_taken = 1'b1; bus.upd_target = 32'h80;
        tick();
        idle();
        #2 nRST = 1'b1;
        tick();
        total++; if (bus.imemaddr !== 32'h0) begin bad++; $display("FAIL ar_hold got=%h exp=0", bus.imemaddr); end
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL ar_noupd got=%b exp=0", bus.pred_taken); end
        redir(32'h300);
        total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL ar_miss got=%b exp=0", bus.pred_taken); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST  = 1'b1;
        idle();
        test_reset();
        test_sequential();
        test_alloc();
        test_counter();
        test_alias();
        test_conflict();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
